// File: rtl/cp0_timer_intc_if.sv
// mtc0/mfc0 access port between cp0 (master) and the timer/interrupt unit (slave).
interface cp0_timer_intc_if;
    logic        wen;
    logic [4:0]  reg_num;
    logic [2:0]  sel;
    logic [31:0] reg_in;
    logic [31:0] reg_out;

    modport master (output wen, output reg_num, output sel, output reg_in, input reg_out);
    modport slave  (input wen, input reg_num, input sel, input reg_in, output reg_out);
endinterface

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with prescaler, multiple compare channels, hw-interrupt
// synchronisers and the Cause.IP / interrupt-pending view handed back to cp0.
module cp0_timer_intc #(
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned NUM_CMP     = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMER_IP    = 7
) (
    input  logic               clk,
    input  logic               reset,
    cp0_timer_intc_if.slave    bus,
    input  logic               count_stop,
    input  logic [5:0]         hw_int,
    input  logic [1:0]         sw_ip,
    input  logic [7:0]         status_im,
    input  logic               status_ie,
    input  logic               status_exl,
    output logic [7:0]         cause_ip,
    output logic [NUM_CMP-1:0] timer_ti,
    output logic               int_pending
);
    localparam int unsigned    PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [4:0]     REG_COUNT   = 5'd9;
    localparam logic [4:0]     REG_COMPARE = 5'd11;
    localparam logic [2:0]     TIP         = 3'(TIMER_IP);

    logic [PW-1:0]      presc_q, presc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q [NUM_CMP];
    logic [NUM_CMP-1:0] ti_q, ti_d, cmp_we;
    logic [5:0]         sync_q [SYNC_STAGES];
    logic               count_we, count_inc, count_upd;

    always_comb begin
        count_we  = bus.wen && (bus.reg_num == REG_COUNT) && (bus.sel == 3'd0);
        count_inc = !count_stop && (presc_q == PRESC_LAST);
        count_upd = count_we || count_inc;
        presc_d   = presc_q;
        count_d   = count_q;
        // A COUNT write restarts the prescaler phase and beats any same-cycle increment.
        if (count_we) begin
            count_d = bus.reg_in;
            presc_d = '0;
        end else if (count_inc) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else if (!count_stop) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_comb begin
        cmp_we = '0;
        ti_d   = '0;
        for (int k = 0; k < int'(NUM_CMP); k++) begin
            cmp_we[k] = bus.wen && (bus.reg_num == REG_COMPARE) && (bus.sel == 3'(k));
            // Only a Count update can set a flag; a compare write always clears it.
            ti_d[k]   = cmp_we[k] ? 1'b0
                                  : (ti_q[k] | (count_upd && (count_d == cmp_q[k])));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            ti_q    <= '0;
            for (int k = 0; k < int'(NUM_CMP); k++) cmp_q[k] <= '1;
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            ti_q    <= ti_d;
            for (int k = 0; k < int'(NUM_CMP); k++) begin
                if (cmp_we[k]) cmp_q[k] <= bus.reg_in;
            end
            sync_q[0] <= hw_int;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        bus.reg_out = '0;
        if ((bus.reg_num == REG_COUNT) && (bus.sel == 3'd0)) begin
            bus.reg_out = count_q;
        end else if (bus.reg_num == REG_COMPARE) begin
            for (int k = 0; k < int'(NUM_CMP); k++) begin
                if (bus.sel == 3'(k)) bus.reg_out = cmp_q[k];
            end
        end
    end

    always_comb begin
        cause_ip      = {sync_q[SYNC_STAGES-1], sw_ip};
        cause_ip[TIP] = cause_ip[TIP] | (|ti_q);
    end

    assign timer_ti    = ti_q;
    assign int_pending = status_ie & ~status_exl & (|(cause_ip & status_im));
endmodule
